// File: rtl/reorder_buffer_mw_if.sv
// Bundled dispatch, operand-read, CDB, flush and retire signals of the reorder buffer.
// The ROB side uses the slave modport; dispatch/RS/commit logic uses the master modport.
interface reorder_buffer_mw_if #(
    parameter int unsigned DEPTH_W    = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 6,
    parameter int unsigned OP_W       = 32,
    parameter int unsigned N_READ     = 6,
    parameter int unsigned N_CDB      = 2,
    parameter int unsigned RETIRE_W   = 2
) ();
    logic                           i_valid;
    logic                           i_ready;
    logic [DEPTH_W-1:0]             i_rsv_id;
    logic [REG_ADDR_W-1:0]          i_dst_reg;
    logic                           i_no_wait;
    logic [OP_W-1:0]                i_opcode;
    logic [N_READ*DEPTH_W-1:0]      rd_id;
    logic [N_READ*DATA_W-1:0]       rd_data;
    logic [N_READ-1:0]              rd_filled;
    logic [N_CDB-1:0]               cdb_valid;
    logic [N_CDB*DEPTH_W-1:0]       cdb_id;
    logic [N_CDB*DATA_W-1:0]        cdb_data;
    logic [N_CDB-1:0]               cdb_exception;
    logic                           flush;
    logic [RETIRE_W-1:0]            o_valid;
    logic [RETIRE_W-1:0]            o_ready;
    logic [RETIRE_W*DEPTH_W-1:0]    o_id;
    logic [RETIRE_W*REG_ADDR_W-1:0] o_dst_reg;
    logic [RETIRE_W*OP_W-1:0]       o_opcode;
    logic [RETIRE_W*DATA_W-1:0]     o_data;
    logic                           o_exception;
    logic [DEPTH_W:0]               o_count;

    modport slave (
        input  i_valid, i_dst_reg, i_no_wait, i_opcode, rd_id,
               cdb_valid, cdb_id, cdb_data, cdb_exception, flush, o_ready,
        output i_ready, i_rsv_id, rd_data, rd_filled,
               o_valid, o_id, o_dst_reg, o_opcode, o_data, o_exception, o_count
    );

    modport master (
        output i_valid, i_dst_reg, i_no_wait, i_opcode, rd_id,
               cdb_valid, cdb_id, cdb_data, cdb_exception, flush, o_ready,
        input  i_ready, i_rsv_id, rd_data, rd_filled,
               o_valid, o_id, o_dst_reg, o_opcode, o_data, o_exception, o_count
    );
endinterface

// File: rtl/reorder_buffer_mw.sv
// Reorder buffer: in-order allocation, multi-port CDB capture with read forwarding,
// multi-lane in-order retire, precise-exception self-flush and mispredict flush.
module reorder_buffer_mw #(
    parameter int unsigned DEPTH_W    = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 6,
    parameter int unsigned OP_W       = 32,
    parameter int unsigned N_READ     = 6,
    parameter int unsigned N_CDB      = 2,
    parameter int unsigned RETIRE_W   = 2
) (
    input logic              clk,
    input logic              nrst,
    reorder_buffer_mw_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_W;
    localparam int unsigned CNT_W = DEPTH_W + 1;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic                  exc;
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] dst;
        logic [OP_W-1:0]       op;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [DEPTH_W-1:0] head_q, head_d;
    logic [DEPTH_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic                alloc_c;
    logic                self_flush_c;
    logic                acc_c;
    logic [RETIRE_W-1:0] ovld_c;
    logic [RETIRE_W-1:0] retire_c;
    logic [CNT_W-1:0]    n_ret_c;
    logic [DEPTH_W-1:0]  lane_idx [RETIRE_W];
    logic [DEPTH_W-1:0]  cdb_idx;
    logic [DEPTH_W-1:0]  rd_idx;
    logic [DEPTH_W-1:0]  hit_idx;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;

    // Occupancy comes from the counter so a full buffer is never confused with empty.
    assign bus.i_ready  = (count_q != CNT_W'(DEPTH)) && !bus.flush;
    assign alloc_c      = bus.i_valid && bus.i_ready;
    assign bus.i_rsv_id = tail_q;
    assign bus.o_count  = count_q;

    for (genvar g = 0; g < RETIRE_W; g++) begin : g_lane
        assign lane_idx[g] = head_q + DEPTH_W'(g);
    end

    // Retire lanes: a contiguous run of ready entries; a faulted entry only ever sits in lane 0.
    always_comb begin : retire_lanes
        ovld_c        = '0;
        retire_c      = '0;
        n_ret_c       = '0;
        acc_c         = 1'b1;
        bus.o_id      = '0;
        bus.o_dst_reg = '0;
        bus.o_opcode  = '0;
        bus.o_data    = '0;
        ovld_c[0] = ent_q[head_q].valid && ent_q[head_q].ready;
        for (int k = 1; k < RETIRE_W; k++) begin
            ovld_c[k] = ovld_c[k-1] && !ent_q[head_q].exc &&
                        ent_q[lane_idx[k]].valid && ent_q[lane_idx[k]].ready &&
                        !ent_q[lane_idx[k]].exc;
        end
        for (int k = 0; k < RETIRE_W; k++) begin
            bus.o_id[k*DEPTH_W +: DEPTH_W]          = lane_idx[k];
            bus.o_dst_reg[k*REG_ADDR_W +: REG_ADDR_W] = ent_q[lane_idx[k]].dst;
            bus.o_opcode[k*OP_W +: OP_W]            = ent_q[lane_idx[k]].op;
            bus.o_data[k*DATA_W +: DATA_W]          = ent_q[lane_idx[k]].data;
            acc_c       = acc_c && ovld_c[k] && bus.o_ready[k];
            retire_c[k] = acc_c;
            n_ret_c     = n_ret_c + CNT_W'(acc_c);
        end
    end

    assign bus.o_valid     = ovld_c;
    assign bus.o_exception = ovld_c[0] && ent_q[head_q].exc;
    assign self_flush_c    = retire_c[0] && ent_q[head_q].exc;

    // Operand reads see this cycle's CDB broadcasts; the highest-index port wins, as for writes.
    always_comb begin : read_ports
        bus.rd_data   = '0;
        bus.rd_filled = '0;
        rd_idx        = '0;
        hit_idx       = '0;
        fwd_hit       = 1'b0;
        fwd_data      = '0;
        for (int r = 0; r < N_READ; r++) begin
            rd_idx   = bus.rd_id[r*DEPTH_W +: DEPTH_W];
            fwd_hit  = 1'b0;
            fwd_data = '0;
            for (int p = 0; p < N_CDB; p++) begin
                hit_idx = bus.cdb_id[p*DEPTH_W +: DEPTH_W];
                if (bus.cdb_valid[p] && (hit_idx == rd_idx)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = bus.cdb_data[p*DATA_W +: DATA_W];
                end
            end
            bus.rd_filled[r] = ent_q[rd_idx].valid && (fwd_hit || ent_q[rd_idx].ready);
            bus.rd_data[r*DATA_W +: DATA_W] = fwd_hit ? fwd_data : ent_q[rd_idx].data;
        end
    end

    // Next state: flush beats everything, then CDB capture, retire, allocate.
    always_comb begin : next_state
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cdb_idx = '0;
        if (bus.flush || self_flush_c) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int p = 0; p < N_CDB; p++) begin
                cdb_idx = bus.cdb_id[p*DEPTH_W +: DEPTH_W];
                if (bus.cdb_valid[p] && ent_q[cdb_idx].valid) begin
                    ent_d[cdb_idx].ready = 1'b1;
                    ent_d[cdb_idx].data  = bus.cdb_data[p*DATA_W +: DATA_W];
                    ent_d[cdb_idx].exc   = bus.cdb_exception[p];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (retire_c[k]) begin
                    ent_d[lane_idx[k]].valid = 1'b0;
                end
            end
            if (alloc_c) begin
                ent_d[tail_q].valid = 1'b1;
                ent_d[tail_q].ready = bus.i_no_wait;
                ent_d[tail_q].exc   = 1'b0;
                ent_d[tail_q].data  = '0;
                ent_d[tail_q].dst   = bus.i_dst_reg;
                ent_d[tail_q].op    = bus.i_opcode;
                tail_d = tail_q + DEPTH_W'(1);
            end
            head_d  = head_q + DEPTH_W'(n_ret_c);
            count_d = count_q + CNT_W'(alloc_c) - n_ret_c;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Reorder buffer bench: directed scenarios with literal expectations plus random traffic,
// all compared each cycle against a queue-based in-order model.
module tb_reorder_buffer_mw;
    localparam int DW    = 3;
    localparam int DEPTH = 8;
    localparam int XW    = 32;
    localparam int NR    = 6;
    localparam int NC    = 2;
    localparam int RW    = 2;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;

    reorder_buffer_mw_if bus ();
    reorder_buffer_mw dut (.clk(clk), .nrst(nrst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          rdy;
        bit          exc;
        logic [31:0] data;
        logic [5:0]  dst;
        logic [31:0] op;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    int   m_nret;
    bit   m_sflush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_id(input int id);
        foreach (q[i]) if (q[i].id == id) return i;
        return -1;
    endfunction

    task automatic idle();
        bus.i_valid = 0; bus.i_dst_reg = '0; bus.i_no_wait = 0; bus.i_opcode = '0;
        bus.rd_id = '0; bus.cdb_valid = '0; bus.cdb_id = '0; bus.cdb_data = '0;
        bus.cdb_exception = '0; bus.flush = 0; bus.o_ready = '0;
    endtask

    // Expected outputs straight from the queue contents and the current inputs.
    task automatic compare_model();
        bit ov [RW];
        bit anyexc;
        int n;
        chk("i_ready", 64'(bus.i_ready), 64'((q.size() < DEPTH) && !bus.flush));
        chk("i_rsv_id", 64'(bus.i_rsv_id), 64'(m_tail));
        chk("o_count", 64'(bus.o_count), 64'(q.size()));
        for (int k = 0; k < RW; k++) begin
            anyexc = 0;
            for (int j = 0; j <= k && j < q.size(); j++) anyexc |= q[j].exc;
            ov[k] = (k < q.size()) && q[k].rdy;
            if (k > 0) ov[k] = ov[k] && ov[k-1] && !anyexc;
            chk("o_valid", 64'(bus.o_valid[k]), 64'(ov[k]));
            if (ov[k]) begin
                chk("o_id", 64'(bus.o_id[k*DW +: DW]), 64'(q[k].id));
                chk("o_dst_reg", 64'(bus.o_dst_reg[k*6 +: 6]), 64'(q[k].dst));
                chk("o_opcode", 64'(bus.o_opcode[k*32 +: 32]), 64'(q[k].op));
                chk("o_data", 64'(bus.o_data[k*XW +: XW]), 64'(q[k].data));
            end
        end
        chk("o_exception", 64'(bus.o_exception), 64'(ov[0] && q[0].exc));
        n = 0;
        for (int k = 0; k < RW; k++) if (ov[k] && bus.o_ready[k] && n == k) n++;
        m_nret   = n;
        m_sflush = (n > 0) && q[0].exc;
        for (int r = 0; r < NR; r++) begin
            int id, idx;
            bit hit, filled;
            logic [31:0] d;
            id  = int'(bus.rd_id[r*DW +: DW]);
            idx = find_id(id);
            hit = 0; d = '0;
            for (int p = 0; p < NC; p++)
                if (bus.cdb_valid[p] && int'(bus.cdb_id[p*DW +: DW]) == id) begin
                    hit = 1; d = bus.cdb_data[p*XW +: XW];
                end
            filled = (idx >= 0) && (hit || q[idx].rdy);
            if (idx >= 0 && !hit) d = q[idx].data;
            chk("rd_filled", 64'(bus.rd_filled[r]), 64'(filled));
            if (filled) chk("rd_data", 64'(bus.rd_data[r*XW +: XW]), 64'(d));
        end
    endtask

    task automatic model_update();
        bit   alloc;
        ent_t e;
        if (bus.flush) begin q.delete(); m_tail = 0; return; end
        alloc = bus.i_valid && (q.size() < DEPTH);
        for (int p = 0; p < NC; p++) begin
            int idx;
            idx = find_id(int'(bus.cdb_id[p*DW +: DW]));
            if (bus.cdb_valid[p] && idx >= 0) begin
                q[idx].rdy  = 1;
                q[idx].data = bus.cdb_data[p*XW +: XW];
                q[idx].exc  = bus.cdb_exception[p];
            end
        end
        if (m_sflush) begin q.delete(); m_tail = 0; return; end
        repeat (m_nret) void'(q.pop_front());
        if (alloc) begin
            e.id = m_tail; e.rdy = bus.i_no_wait; e.exc = 0; e.data = '0;
            e.dst = bus.i_dst_reg; e.op = bus.i_opcode;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic cycle();
        #1;
        compare_model();
        model_update();
        @(negedge clk);
    endtask

    task automatic alloc_n(input int n, input bit no_wait);
        for (int k = 0; k < n; k++) begin
            idle();
            bus.i_valid = 1; bus.i_no_wait = no_wait;
            bus.i_dst_reg = 6'(k + 3); bus.i_opcode = 32'h100 + 32'(k);
            cycle();
        end
        idle();
    endtask

    task automatic do_flush();
        idle(); bus.flush = 1; cycle(); idle();
    endtask

    initial begin
        checks = 0; failures = 0; m_tail = 0; m_nret = 0; m_sflush = 0;
        nrst = 0; idle();
        repeat (3) @(negedge clk);
        nrst = 1;
        #1;
        chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
        chk("rst_o_count", 64'(bus.o_count), 64'd0);
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_exception", 64'(bus.o_exception), 64'd0);
        chk("rst_rd_filled", 64'(bus.rd_filled), 64'd0);

        // Fill all eight slots; ids come out 0..7 and the ninth request is refused.
        for (int k = 0; k < DEPTH; k++) begin
            idle(); bus.i_valid = 1; bus.i_dst_reg = 6'(k); bus.i_opcode = 32'h200 + 32'(k);
            #1;
            chk("fill_id", 64'(bus.i_rsv_id), 64'(k));
            chk("fill_ready", 64'(bus.i_ready), 64'd1);
            cycle();
        end
        bus.i_valid = 1;
        #1;
        chk("full_ready", 64'(bus.i_ready), 64'd0);
        chk("full_count", 64'(bus.o_count), 64'd8);
        cycle();
        idle(); #1;
        chk("ninth_ignored", 64'(bus.o_count), 64'd8);
        do_flush(); #1;
        chk("flush_count", 64'(bus.o_count), 64'd0);
        chk("flush_tail", 64'(bus.i_rsv_id), 64'd0);

        // Two ports complete out of order in one cycle; both lanes valid the next cycle.
        alloc_n(2, 0);
        bus.cdb_valid = 2'b11;
        bus.cdb_id    = {3'd0, 3'd1};
        bus.cdb_data  = {32'hA, 32'hB};
        #1;
        chk("no_bypass", 64'(bus.o_valid), 64'd0);
        cycle();
        idle(); #1;
        chk("two_lane_valid", 64'(bus.o_valid), 64'd3);
        chk("lane0_data", 64'(bus.o_data[31:0]), 64'hA);
        chk("lane1_data", 64'(bus.o_data[63:32]), 64'hB);
        bus.o_ready = 2'b11;
        cycle();
        idle(); #1;
        chk("drained", 64'(bus.o_count), 64'd0);

        // Forwarding of a same-cycle broadcast to entry 3, then two-port priority.
        alloc_n(2, 0);
        bus.rd_id = 18'(3); bus.cdb_valid = 2'b01; bus.cdb_id = 6'(3); bus.cdb_data = 64'h55;
        #1;
        chk("fwd_filled", 64'(bus.rd_filled[0]), 64'd1);
        chk("fwd_data", 64'(bus.rd_data[31:0]), 64'h55);
        cycle();
        idle();
        bus.rd_id = 18'(3); bus.cdb_valid = 2'b11; bus.cdb_id = {3'd3, 3'd3};
        bus.cdb_data = {32'h22, 32'h11};
        #1;
        chk("fwd_prio", 64'(bus.rd_data[31:0]), 64'h22);
        cycle();
        idle(); bus.rd_id = 18'(3); #1;
        chk("stored_prio", 64'(bus.rd_data[31:0]), 64'h22);
        do_flush();

        // Wrap: full buffer drained two per cycle while re-allocating.
        alloc_n(8, 1);
        #1;
        chk("wrap_full", 64'(bus.o_count), 64'd8);
        chk("wrap_tail", 64'(bus.i_rsv_id), 64'd0);
        bus.o_ready = 2'b11; bus.i_valid = 1; bus.i_no_wait = 1;
        cycle();
        #1;
        chk("wrap_count", 64'(bus.o_count), 64'd6);
        chk("wrap_head", 64'(bus.o_id[2:0]), 64'd2);
        for (int k = 0; k < 12; k++) begin
            bus.o_ready = 2'b11; bus.i_valid = 1; bus.i_no_wait = 1;
            bus.i_opcode = $urandom; bus.i_dst_reg = 6'($urandom);
            cycle();
        end
        idle(); bus.o_ready = 2'b11;
        repeat (5) cycle();
        #1;
        chk("wrap_drained", 64'(bus.o_count), 64'd0);
        do_flush();

        // Faulting head retires alone and empties the buffer.
        alloc_n(2, 0);
        bus.cdb_valid = 2'b11; bus.cdb_id = {3'd1, 3'd0};
        bus.cdb_data = {32'h1, 32'hE}; bus.cdb_exception = 2'b01;
        cycle();
        idle(); #1;
        chk("exc_lane0_only", 64'(bus.o_valid), 64'd1);
        chk("exc_flag", 64'(bus.o_exception), 64'd1);
        bus.o_ready = 2'b11;
        cycle();
        idle(); #1;
        chk("exc_count", 64'(bus.o_count), 64'd0);
        chk("exc_tail", 64'(bus.i_rsv_id), 64'd0);
        chk("exc_head", 64'(bus.o_id[2:0]), 64'd0);

        // Flush wins over allocate, CDB and retire in the same cycle.
        alloc_n(3, 1);
        bus.flush = 1; bus.i_valid = 1; bus.cdb_valid = 2'b11;
        bus.cdb_id = {3'd1, 3'd0}; bus.o_ready = 2'b11;
        #1;
        chk("flush_blocks_alloc", 64'(bus.i_ready), 64'd0);
        cycle();
        idle(); #1;
        chk("flush_empty", 64'(bus.o_count), 64'd0);
        chk("flush_ids", 64'(bus.i_rsv_id), 64'd0);
        chk("flush_ovalid", 64'(bus.o_valid), 64'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.i_valid   = ($urandom_range(0, 9) < 6);
            bus.i_dst_reg = 6'($urandom);
            bus.i_no_wait = ($urandom_range(0, 3) == 0);
            bus.i_opcode  = $urandom;
            for (int r = 0; r < NR; r++) bus.rd_id[r*DW +: DW] = 3'($urandom);
            for (int p = 0; p < NC; p++) begin
                bus.cdb_valid[p]          = 1'($urandom_range(0, 1));
                bus.cdb_id[p*DW +: DW]    = 3'($urandom);
                bus.cdb_data[p*XW +: XW]  = $urandom;
                bus.cdb_exception[p]      = ($urandom_range(0, 15) == 0);
            end
            bus.o_ready = 2'($urandom);
            bus.flush   = ($urandom_range(0, 49) == 0);
            cycle();
        end

        // Asynchronous reset mid-operation discards everything.
        idle(); alloc_n(3, 1);
        nrst = 0;
        #1;
        chk("mid_rst_count", 64'(bus.o_count), 64'd0);
        chk("mid_rst_ovalid", 64'(bus.o_valid), 64'd0);
        q.delete(); m_tail = 0;
        @(negedge clk);
        nrst = 1;
        alloc_n(2, 1);
        bus.o_ready = 2'b11;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
